umips_muldiv_unit: RTL and testbench

//  Iterative HI/LO multiply/divide unit for the umips 5-stage pipeline, fed from the execute stage.
//  It is the stall-requesting end of the hazard interface: it raises stall_req whenever a decode-stage

---
 rtl/umips_muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_umips_muldiv_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/umips_muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, plus a sign-fixup cycle. Drives the stall request for the hazard logic.
module umips_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             start_e,
    input  logic [2:0]       op_e,
    input  logic [WIDTH-1:0] a_e,
    input  logic [WIDTH-1:0] b_e,
    input  logic             hilo_use_d,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall_req
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH:0]   prod;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   raw_a;
    logic               neg_q;
    logic               neg_r;
    logic               div_op;
    logic               div0;

    logic               is_mul;
    logic               is_div;
    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               last_iter;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_trial;
    logic               div_ok;
    logic [2*WIDTH-1:0] prod_fix;

    assign is_mul    = start_e && (op_e == 3'd0 || op_e == 3'd1);
    assign is_div    = start_e && (op_e == 3'd2 || op_e == 3'd3);
    assign signed_op = (op_e == 3'd0) || (op_e == 3'd2);
    assign a_neg     = signed_op && a_e[WIDTH-1];
    assign b_neg     = signed_op && b_e[WIDTH-1];
    assign a_mag     = a_neg ? ('0 - a_e) : a_e;
    assign b_mag     = b_neg ? ('0 - b_e) : b_e;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // Multiply: upper half accumulates, multiplier bits shift out of the low end.
    assign mul_sum   = prod[2*WIDTH:WIDTH] + (prod[0] ? {1'b0, mcand} : '0);

    // Restoring divide: remainder and dividend shift left together; quotient bits enter quo.
    assign div_shift = {rem, quo[WIDTH-1]};
    assign div_trial = {1'b0, div_shift} - {2'b00, mcand};
    assign div_ok    = !div_trial[WIDTH+1];

    assign prod_fix  = neg_q ? ('0 - prod[2*WIDTH-1:0]) : prod[2*WIDTH-1:0];

    assign stall_req = busy & hilo_use_d;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (is_mul)      state_nxt = MUL;
                else if (is_div) state_nxt = DIV;
            end
            MUL, DIV: begin
                if (last_iter) state_nxt = FIX;
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            prod   <= '0;
            rem    <= '0;
            quo    <= '0;
            raw_a  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div_op <= 1'b0;
            div0   <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (is_mul || is_div) begin
                        cnt    <= '0;
                        mcand  <= is_mul ? a_mag : b_mag;
                        prod   <= {{(WIDTH+1){1'b0}}, b_mag};
                        rem    <= '0;
                        quo    <= a_mag;
                        raw_a  <= a_e;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        div_op <= is_div;
                        div0   <= is_div && (b_e == '0);
                    end else if (start_e && op_e == 3'd4) begin
                        hi <= a_e;
                    end else if (start_e && op_e == 3'd5) begin
                        lo <= a_e;
                    end
                end
                MUL: begin
                    cnt  <= cnt + CNT_W'(1);
                    prod <= {1'b0, mul_sum, prod[WIDTH-1:1]};
                end
                DIV: begin
                    cnt <= cnt + CNT_W'(1);
                    rem <= div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], div_ok};
                end
                FIX: begin
                    cnt <= '0;
                    if (div_op) begin
                        if (div0) begin
                            hi <= raw_a;
                            lo <= '1;
                        end else begin
                            hi <= neg_r ? ('0 - rem) : rem;
                            lo <= neg_q ? ('0 - quo) : quo;
                        end
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_umips_muldiv_unit.sv
// Self-checking bench for umips_muldiv_unit: directed corner cases plus random
// mult/div ops checked against an arithmetic reference model.
module tb_umips_muldiv_unit;

    logic        clk;
    logic        n_reset;
    logic        start_e;
    logic [2:0]  op_e;
    logic [31:0] a_e;
    logic [31:0] b_e;
    logic        hilo_use_d;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall_req;

    int unsigned n_checks;
    int unsigned n_fail;
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    umips_muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .start_e    (start_e),
        .op_e       (op_e),
        .a_e        (a_e),
        .b_e        (b_e),
        .hilo_use_d (hilo_use_d),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .stall_req  (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {hi,lo} as defined by the MIPS HI/LO rules, using plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        res = '0;
        case (op)
            3'd0: res = 64'(sa * sb);
            3'd1: res = ua * ub;
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if (op == 3'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end else begin
                    q = longint'(ua / ub);
                    r = longint'(ua % ub);
                    res = {r[31:0], q[31:0]};
                end
            end
            default: res = {hi_m, lo_m};
        endcase
        return res;
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit all_use, input bit inject);
        logic [63:0] exp;
        int unsigned nbusy;
        int unsigned nstall;
        exp = ref_result(op, a, b);
        @(negedge clk);
        start_e    = 1'b1;
        op_e       = op;
        a_e        = a;
        b_e        = b;
        hilo_use_d = 1'b0;
        @(posedge clk);
        #1;
        start_e = 1'b0;
        a_e     = $urandom;
        b_e     = $urandom;
        nbusy   = 0;
        nstall  = 0;
        while (busy && nbusy < 100) begin
            hilo_use_d = all_use ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            check("stall_in_flight", {63'b0, stall_req}, {63'b0, hilo_use_d});
            if (stall_req) nstall++;
            check("hold_hilo", {hi, lo}, {hi_m, lo_m});
            if (inject && nbusy == 5) begin
                start_e = 1'b1;
                op_e    = 3'd1;
                a_e     = 32'h0000_0005;
                b_e     = 32'h0000_0009;
            end
            nbusy++;
            @(posedge clk);
            #1;
            start_e = 1'b0;
        end
        hilo_use_d = 1'b1;
        #1;
        check("busy_cycles", 64'(nbusy), 64'd33);
        check("stall_after", {63'b0, stall_req}, 64'd0);
        if (all_use) check("stall_cycles", 64'(nstall), 64'd33);
        check("hi", {32'b0, hi}, {32'b0, exp[63:32]});
        check("lo", {32'b0, lo}, {32'b0, exp[31:0]});
        hi_m = exp[63:32];
        lo_m = exp[31:0];
        hilo_use_d = 1'b0;
    endtask

    task automatic mt_op(input logic [2:0] op, input logic [31:0] a);
        @(negedge clk);
        start_e = 1'b1;
        op_e    = op;
        a_e     = a;
        @(posedge clk);
        #1;
        start_e = 1'b0;
        if (op == 3'd4) hi_m = a;
        if (op == 3'd5) lo_m = a;
        check("mt_busy", {63'b0, busy}, 64'd0);
        check("mt_hilo", {hi, lo}, {hi_m, lo_m});
        @(posedge clk);
        #1;
        check("mt_busy_late", {63'b0, busy}, 64'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h8000_0000;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'($signed($urandom_range(0, 40)) - 20);
            3:       v = 32'd0;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        hi_m       = '0;
        lo_m       = '0;
        n_reset    = 1'b0;
        start_e    = 1'b0;
        op_e       = 3'd0;
        a_e        = '0;
        b_e        = '0;
        hilo_use_d = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        n_reset = 1'b1;

        mt_op(3'd4, 32'h1234_5678);
        mt_op(3'd5, 32'h9ABC_DEF0);
        mt_op(3'd6, 32'hDEAD_BEEF);
        mt_op(3'd7, 32'hCAFE_F00D);

        // Reset during a multiply whose counter has reached 10.
        @(negedge clk);
        start_e = 1'b1;
        op_e    = 3'd1;
        a_e     = 32'hFFFF_0000;
        b_e     = 32'h0000_FFFF;
        @(posedge clk);
        #1;
        start_e = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("mid_busy", {63'b0, busy}, 64'd1);
        n_reset = 1'b0;
        #1;
        hi_m = '0;
        lo_m = '0;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        n_reset = 1'b1;

        run_op(3'd1, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, 1'b0);
        check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
        check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'd3, 32'd100, 32'd0, 1'b0, 1'b0);
        check("divu_zero", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(3'd2, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0);
        run_op(3'd0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);

        for (int i = 0; i < 24; i++) begin
            run_op(3'($urandom_range(0, 3)), pick_operand(), pick_operand(), 1'b0, 1'($urandom_range(0, 1)));
        end

        mt_op(3'd4, 32'h0BAD_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
